// File: rtl/rf_write_scheduler_pkg.sv
// Shared constants for the register-file write scheduler: register file geometry,
// requester slot assignments and the address-to-enable decode.
package rf_write_scheduler_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 16;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;
  localparam int REQ_CP0    = 3;

  function automatic logic [RF_DEPTH-1:0] addr_onehot(input logic [RF_ADDR_W-1:0] addr);
    logic [RF_DEPTH-1:0] oh;
    oh = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above
// ptr, wrapping from NREQ-1 back to 0. Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the single register-file write port between NREQ requesters using a
// round-robin grant and issues a registered one-cycle write command per transfer.
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DW           = 32,
  parameter bit DISCARD_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [4*NREQ-1:0]       req_addr,
  input  logic [DW*NREQ-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    rf_stall,
  output logic [15:0]             rf_we,
  output logic [3:0]              rf_waddr,
  output logic [DW-1:0]           rf_wdata,
  output logic [$clog2(NREQ)-1:0] last_grant,
  output logic [7:0]              discard_cnt
);

  localparam int IW = $clog2(NREQ);

  // Handshake: requester i transfers at the rising edge where req_valid[i] and
  // req_ready[i] are both high; it holds addr/data stable until then.
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gidx;
  logic [NREQ-1:0]      req_masked;
  logic [NREQ-1:0]      grant;
  logic [RF_ADDR_W-1:0] sel_addr;
  logic [DW-1:0]        sel_data;
  logic                 xfer;
  logic                 drop;

  // No grant while the register file stalls or while held in reset.
  assign req_masked = (rst_n && !rf_stall) ? req_valid : '0;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_masked),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_addr  = req_addr[int'(gidx)*RF_ADDR_W +: RF_ADDR_W];
  assign sel_data  = req_data[int'(gidx)*DW +: DW];
  assign drop      = DISCARD_ZERO && (sel_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      last_grant  <= '0;
      rf_we       <= '0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      discard_cnt <= '0;
    end else begin
      rf_we <= '0;
      if (xfer) begin
        ptr        <= (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
        last_grant <= gidx;
        rf_waddr   <= sel_addr;
        rf_wdata   <= sel_data;
        // Discarded writes still complete and update address/data, but raise no enable.
        if (drop) begin
          if (discard_cnt != 8'hFF) discard_cnt <= discard_cnt + 8'd1;
        end else begin
          rf_we <= addr_onehot(sel_addr);
        end
      end
    end
  end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Shares the single register-file write port between NREQ requesters (e.g. ALU writeback, load return, mult/div unit, CP0 move).
- Arbitrates round-robin and decodes the 4-bit destination address to a 16-bit one-hot write enable.
- Drives a registered write command for one cycle.
- Sits between the execution/writeback units and the 16-entry register file.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, write data width.
- DISCARD_ZERO, 1, when 1, writes to address 0 complete the handshake but produce no enable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  4*NREQ  destination address; requester i uses bits [4i+3:4i].
- req_data  in  DW*NREQ  write data; requester i uses bits [DW*i+DW-1:DW*i].
- req_ready  out  NREQ  one-hot grant; the write transfers when valid and ready are both high.
- rf_stall  in  1  register file cannot accept a write this cycle.
- rf_we  out  16  registered one-hot write enable.
- rf_waddr  out  4  registered write address.
- rf_wdata  out  DW  registered write data.
- last_grant  out  clog2(NREQ)  index of the most recently granted requester.
- discard_cnt  out  8  count of discarded address-0 writes; saturates at 255.

Behaviour:
- Reset (asynchronous, rst_n low) sets:
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - round-robin pointer=0, so requester 0 has highest priority;
  - last_grant=0, discard_cnt=0.
- While rst_n is low, req_ready=0.
- Grant (combinational):
  - If rf_stall=1 or no req_valid bit is set, req_ready=0.
  - Otherwise exactly one bit is set: the first valid requester, searching upward from the pointer and wrapping from NREQ-1 to 0.
  - req_ready never asserts for a requester whose valid is low.
- Handshake:
  - A requester holds valid, addr and data stable until it sees ready.
  - The transfer happens at the clock edge where valid&ready=1.
  - Valid may drop only after the transfer.
- Pointer update: on a transfer by requester g, the pointer becomes (g+1) mod NREQ and last_grant becomes g. With no transfer, both hold.
- Latency:
  - A transfer at edge N drives the write command in the cycle after edge N: rf_we=onehot(addr), rf_waddr=addr, rf_wdata=data.
  - rf_we is high for exactly one cycle.
  - Back-to-back transfers give back-to-back single-cycle enables.
- Idle:
  - With no transfer, rf_we=0 on the next cycle.
  - rf_waddr and rf_wdata hold their last values; they are don't-care while rf_we=0.
- Stall:
  - rf_stall is sampled combinationally.
  - A command already registered is not retracted; the register file guarantees it accepts any enable issued in the cycle before a stall.
- Address 0 with DISCARD_ZERO=1:
  - The transfer completes and the pointer advances.
  - rf_we=0, and rf_waddr/rf_wdata still update.
  - discard_cnt increments and saturates at 255.
- Address 0 with DISCARD_ZERO=0: it is a normal write, rf_we=16'h0001.
- Same address from several requesters in one cycle: each is served in round-robin order on successive cycles. Later writes win in the register file; no merging.
- Reset mid-operation: a pending rf_we pulse is cleared immediately, and the pointer returns to 0.

Decomposition:
- Shared package holds:
  - RF_ADDR_W=4, RF_DEPTH=16;
  - the requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2, REQ_CP0=3.
- Natural sub-module: rr_arbiter, parameterised on NREQ.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The pointer register, address decode and output registers stay in rf_write_scheduler.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low, then high; no valid.
  - Response: rf_we=0, req_ready=0, discard_cnt=0, last_grant=0 throughout.
- Single write:
  - Stimulus: req 1 valid, addr 5, data 32'hDEADBEEF.
  - Response: req_ready=4'b0010 in the same cycle; next cycle rf_we=16'h0020, rf_waddr=5, rf_wdata=32'hDEADBEEF; the cycle after, rf_we=0.
- All four requesters continuously valid, addrs 1,2,3,4:
  - Grants in order 0,1,2,3,0.
  - rf_we sequence 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0002, with no gaps.
- Stall:
  - Stimulus: reqs 0 and 2 valid, rf_stall high for 3 cycles, then low.
  - Response: req_ready=0 and no new rf_we during the stall; then req 0 is granted, followed by req 2.
- Discard:
  - Stimulus: req 3 writes addr 0 three times, DISCARD_ZERO=1.
  - Response: three handshakes complete, rf_we stays 0, discard_cnt=3.
  - Repeating 300 times saturates discard_cnt at 255.
- Reset mid-operation:
  - Stimulus: assert rst_n low in the cycle rf_we=16'h0100.
  - Response: rf_we=0 immediately; after release the pointer=0 and req 0 wins against req 2.
